// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache miss ports for the
// shared main memory. It sequences each access as SETUP -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int MEM_WAIT = 2,
    parameter int ADDR_MAX = 1020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [9:0]  addr0,
    input  logic [9:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_rw,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [9:0] AMAX = 10'(ADDR_MAX);
    localparam logic [4:0] WAIT = 5'(MEM_WAIT);

    state_t      state;
    logic        last_grant;
    logic        grant;
    logic        cap_we;
    logic [3:0]  count;
    logic [4:0]  count_nx;
    logic        sel;
    logic        sel_we;
    logic [9:0]  sel_addr;
    logic [31:0] sel_wdata;

    // On a tie the port that was not served last wins.
    always_comb begin
        sel = req1;
        if (req0 && req1) begin
            sel = ~last_grant;
        end
        sel_we    = sel ? we1 : we0;
        sel_addr  = sel ? addr1 : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
    end

    assign count_nx = {1'b0, count} + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cap_we     <= 1'b0;
            count      <= 4'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= 32'd0;
            rdata1     <= 32'd0;
            mem_rw     <= 1'b0;
            mem_addr   <= 10'd0;
            mem_wdata  <= 32'd0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant  <= sel;
                        cap_we <= sel_we;
                        if (sel_addr > AMAX) begin
                            state <= RESP;
                            if (sel) begin
                                ack1 <= 1'b1;
                                err1 <= 1'b1;
                            end else begin
                                ack0 <= 1'b1;
                                err0 <= 1'b1;
                            end
                        end else begin
                            state     <= SETUP;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                SETUP: begin
                    state  <= ACCESS;
                    mem_rw <= cap_we;
                    count  <= 4'd0;
                end
                ACCESS: begin
                    if (count_nx >= WAIT && mem_done) begin
                        state  <= RESP;
                        mem_rw <= 1'b0;
                        if (grant) begin
                            ack1 <= 1'b1;
                            if (!cap_we) rdata1 <= mem_rdata;
                        end else begin
                            ack0 <= 1'b1;
                            if (!cap_we) rdata0 <= mem_rdata;
                        end
                    end else if (count != 4'hF) begin
                        count <= count_nx[3:0];
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared byte-addressable main memory (1024 bytes, 32-bit little-endian word access, level-triggered, self-timed `Done`). It sits between the instruction-cache miss port (port 0) and the data-cache miss/writeback port (port 1). It grants one request at a time using round-robin priority. It drives the memory pins so that every access is triggered exactly once, and it returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- `MEM_WAIT`, 2: minimum clock cycles spent in ACCESS before `mem_done` is sampled; range 1–15.
- `ADDR_MAX`, 1020: highest legal start address; a word occupies `addr`..`addr+3`.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req0`, `req1` input 1: request; held high with fields stable until the matching `ack`.
- `we0`, `we1` input 1: 1 = write, 0 = read.
- `addr0`, `addr1` input 10: byte start address.
- `wdata0`, `wdata1` input 32: write data.
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `err0`, `err1` output 1: valid with `ack`; 1 = address out of range, no access performed.
- `rdata0`, `rdata1` output 32: read data; updated only on a read `ack` to that port, held otherwise.
- `mem_rw` output 1: to memory `read_write_mem`.
- `mem_addr` output 10: to memory `address_mem`.
- `mem_wdata` output 32: to memory `write_data_mem`.
- `mem_rdata` input 32: from memory `read_data_mem`.
- `mem_done` input 1: from memory `Done`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If any `req` is high, grant one port. On a tie, grant the port that was not granted last; `last_grant` resets to 1, so port 0 wins the first tie.
  - Capture `we`, `addr` and `wdata` of the granted port into internal registers.
  - If captured `addr > ADDR_MAX`: go to RESP with `err=1`; memory pins unchanged.
  - Otherwise go to SETUP.
- SETUP: drive `mem_addr` and `mem_wdata` from the captured values with `mem_rw=0`. An address change triggers only a harmless read. Go to ACCESS.
- ACCESS:
  - Drive `mem_rw = captured we`. Count cycles.
  - Leave at the first edge where count ≥ `MEM_WAIT` and `mem_done == 1`. Wait indefinitely otherwise.
  - On exit to RESP, if read: latch `mem_rdata` into the granted port's `rdata`.
- RESP:
  - `mem_rw=0`. This deasserts the write before any later address change, so no spurious writes occur; the 1→0 edge re-reads the written word, which is harmless.
  - Pulse the granted port's `ack` (with `err`) for exactly this cycle.
  - Update `last_grant`. Go to IDLE.
- `mem_addr` and `mem_wdata` change only in SETUP. `mem_rw` is 1 only in ACCESS of a write.
- A requester dropping `req` after grant does not abort the operation; `ack` still pulses.
- A request from the non-granted port waits; it is never lost while held high.

## Timing
- Reset (asynchronous, any state):
  - State IDLE; `ack0/1=0`, `err0/1=0`.
  - `rdata0/1=0`, `mem_rw=0`, `mem_addr=0`, `mem_wdata=0`.
  - `last_grant=1`, counter 0.
  - An in-flight operation is dropped with no `ack`.
- Legal access, with `req` sampled at edge t0 and `mem_done` already high when counted:
  - SETUP from t0, ACCESS from t1, RESP from t(1+`MEM_WAIT`).
  - `ack` high from t(1+`MEM_WAIT`) to t(2+`MEM_WAIT`). With default `MEM_WAIT=2`: `ack` high in the 4th cycle after the sampling edge.
- Out-of-range access: `ack` high in the cycle immediately after the sampling edge (1-cycle latency).
- Back-to-back: IDLE is re-entered after RESP, so the next grant occurs one edge later. Legal throughput is one operation per `MEM_WAIT+3` cycles.
- Clock constraint: `MEM_WAIT` × period must exceed the memory completion time (4 ns). This holds for a 10 ns clock at `MEM_WAIT=2`.
- `mem_done` low at the count expiry extends ACCESS cycle by cycle until it is seen high.

## Test plan
- Reset mid-ACCESS of a port-1 write to 0x040 (`rst` pulsed asynchronously between edges): all outputs go to reset values immediately, no `ack1`; a subsequent read of 0x040 returns 0.
- Port 0 write 0xDEADBEEF to 0x010, then port 0 read 0x010: second `ack0` has `err0=0` and `rdata0=0xDEADBEEF`; each `ack` is exactly 1 cycle, 4 cycles after `req` sampling (`MEM_WAIT=2`).
- `req0` and `req1` both high continuously, reading 0x000 and 0x004: grants alternate 0,1,0,1; `ack0` and `ack1` never in the same cycle; the first grant goes to port 0.
- Port 1 read at 0x3FD (> 1020): `ack1=1`, `err1=1` one cycle after sampling; `mem_addr`, `mem_rw` and `rdata1` unchanged.
- Write 0x11223344 to 0x3FC (boundary-legal), then read it back: `rdata=0x11223344`, `err=0`; memory byte 0x3FF holds 0x11.
- Hold `mem_done` low for 5 extra cycles during a read: ACCESS extends accordingly, `ack` is delayed by 5 cycles, and `rdata` is correct; `mem_rw` is never 1 during any read.
